addr_calc_arbiter: RTL and testbench
====================================

Name: addr_calc_arbiter

Overview:
- Shares one address_calculator between two requesters in the out-of-order core: the load reservation station (ld_*) and the store reservation station (st_*).
- Round-robin arbitration feeds a one-entry registered dispatch buffer that drives the calculator's dispatch port.
- A source-tag FIFO records the grant order so each calculator result (execute port) is routed back to the requester that issued it.
- Flush from the ROB discards everything held or in flight.

Parameters:
- XLEN, 64, operand/address width
- ROB_INDEX_WIDTH, 8, ROB index width
- TAG_DEPTH, 4, max requests buffered plus in flight in the calculator (power of 2, ≥2)

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- flush  in  1  ROB flush, synchronous effect
- ld_valid / st_valid  in  1  request valid
- ld_ready / st_ready  out  1  request accepted this cycle when valid&&ready
- ld_1st_reg, ld_2nd_reg, ld_address / st_*  in  XLEN  operands and immediate/address
- ld_ROB_index / st_ROB_index  in  ROB_INDEX_WIDTH  ROB tag
- dispatch_valid  out  1  to calculator
- dispatch_ready  in  1  from calculator
- dispatch_1st_reg, dispatch_2nd_reg, dispatch_address  out  XLEN  buffered payload
- dispatch_ROB_index  out  ROB_INDEX_WIDTH  buffered tag
- calc_valid  in  1  calculator execute_valid
- calc_ready  out  1  to calculator execute_ready
- calc_ROB_index  in  ROB_INDEX_WIDTH  result tag
- calc_value, calc_address  in  XLEN  result
- ld_res_valid / st_res_valid  out  1  routed result valid
- ld_res_ready / st_res_ready  in  1  consumer ready
- res_ROB_index  out  ROB_INDEX_WIDTH  shared result bus
- res_value, res_address  out  XLEN  shared result bus
- tag_underflow  out  1  sticky error flag

Behaviour:
- Reset (asynchronous, active-high):
  - dispatch_valid=0, all dispatch payload=0.
  - FIFO empty, count=0.
  - RR pointer=LD.
  - tag_underflow=0.
  - ld_ready=st_ready=0 while reset is asserted.
- Grant:
  - accept = !flush && fifo_count<TAG_DEPTH && (!dispatch_valid || dispatch_ready).
  - One valid requester: it wins. Both valid: the RR pointer's requester wins.
  - Only the winner sees ready=accept; the loser's ready=0.
  - On acceptance the pointer moves to the other requester. With no acceptance the pointer holds.
- Dispatch buffer:
  - An accepted request is loaded at the clock edge; dispatch_valid=1 the next cycle (1-cycle latency).
  - The payload holds stable while dispatch_valid && !dispatch_ready.
  - Drain and refill in the same cycle are allowed, sustaining 1 request/cycle.
- Tag FIFO:
  - Pushes the winner ID (0=LD, 1=ST) on acceptance.
  - Pops on calc_valid && calc_ready.
  - Push and pop in the same cycle leave count unchanged. The pointer wraps mod TAG_DEPTH.
  - No push when full, even if a pop occurs that cycle (no bypass).
- Result routing (combinational):
  - res_* = calc_*.
  - FIFO head=LD: ld_res_valid=calc_valid, calc_ready=ld_res_ready.
  - FIFO head=ST: st_res_valid=calc_valid, calc_ready=st_res_ready.
  - The unselected res_valid=0.
- Underflow:
  - If calc_valid with the FIFO empty: both res_valid=0, calc_ready=1 (result dropped).
  - tag_underflow is set and stays set until reset.
- Flush (synchronous):
  - At the edge, dispatch_valid←0, FIFO cleared, count←0, pointer←LD.
  - During the flush cycle: ld_ready=st_ready=0, both res_valid=0, calc_ready=1 so stale results are drained.
  - Results arriving after the flush with the FIFO empty are covered by the underflow rule. Flush leaves the calculator's own flush to the ROB.
- Reset mid-operation discards everything immediately.

Test Plan:
- Reset 3 cycles, no requests: dispatch_valid=0, ld_ready=st_ready=0 during reset, tag_underflow=0 after release.
- ld_valid=1 only, ld_ROB_index=5, ld_address=0x100, dispatch_ready=1: ld_ready=1 for one cycle; next cycle dispatch_valid=1, dispatch_ROB_index=5, dispatch_address=0x100.
- ld_valid and st_valid held 4 cycles, dispatch_ready=1, calc never valid: grants go LD,ST,LD,ST; then ready=0 with fifo_count=4=TAG_DEPTH.
- dispatch_ready=0 for 3 cycles with a buffered ST request (ROB 9): payload stable, no further grants; dispatch_ready=1 releases it.
- FIFO holds [LD,ST]; calc_valid with ROB 3, then ROB 7: first ld_res_valid=1, res_ROB_index=3; then st_res_valid=1. With st_res_ready=0 the result stalls (calc_ready=0) and the head is not popped.
- Flush with 2 in flight: count→0, dispatch_valid→0; a subsequent calc_valid pulse → no res_valid, tag_underflow=1 and sticky until reset.

Source files
------------

// File: rtl/addr_calc_arbiter.sv
// Shares one address calculator between the load and store reservation stations:
// round-robin grant into a one-entry dispatch buffer, with a source-tag FIFO routing results back.
module addr_calc_arbiter #(
  parameter int XLEN            = 64,
  parameter int ROB_INDEX_WIDTH = 8,
  parameter int TAG_DEPTH       = 4
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       flush,
  input  logic                       ld_valid,
  output logic                       ld_ready,
  input  logic [XLEN-1:0]            ld_1st_reg,
  input  logic [XLEN-1:0]            ld_2nd_reg,
  input  logic [XLEN-1:0]            ld_address,
  input  logic [ROB_INDEX_WIDTH-1:0] ld_ROB_index,
  input  logic                       st_valid,
  output logic                       st_ready,
  input  logic [XLEN-1:0]            st_1st_reg,
  input  logic [XLEN-1:0]            st_2nd_reg,
  input  logic [XLEN-1:0]            st_address,
  input  logic [ROB_INDEX_WIDTH-1:0] st_ROB_index,
  output logic                       dispatch_valid,
  input  logic                       dispatch_ready,
  output logic [XLEN-1:0]            dispatch_1st_reg,
  output logic [XLEN-1:0]            dispatch_2nd_reg,
  output logic [XLEN-1:0]            dispatch_address,
  output logic [ROB_INDEX_WIDTH-1:0] dispatch_ROB_index,
  input  logic                       calc_valid,
  output logic                       calc_ready,
  input  logic [ROB_INDEX_WIDTH-1:0] calc_ROB_index,
  input  logic [XLEN-1:0]            calc_value,
  input  logic [XLEN-1:0]            calc_address,
  output logic                       ld_res_valid,
  input  logic                       ld_res_ready,
  output logic                       st_res_valid,
  input  logic                       st_res_ready,
  output logic [ROB_INDEX_WIDTH-1:0] res_ROB_index,
  output logic [XLEN-1:0]            res_value,
  output logic [XLEN-1:0]            res_address,
  output logic                       tag_underflow
);

  // Handshake: a transfer happens on a rising edge where valid && ready are both high;
  // a valid holder keeps its payload stable until that edge.

  localparam int PW = (TAG_DEPTH > 1) ? $clog2(TAG_DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(TAG_DEPTH);
  localparam logic [0:0] RR_LD = 1'b0;
  localparam logic [0:0] RR_ST = 1'b1;

  logic [0:0]                 rr_q, rr_d;
  logic                       disp_valid_q, disp_valid_d;
  logic [XLEN-1:0]            disp_1st_q, disp_1st_d;
  logic [XLEN-1:0]            disp_2nd_q, disp_2nd_d;
  logic [XLEN-1:0]            disp_addr_q, disp_addr_d;
  logic [ROB_INDEX_WIDTH-1:0] disp_rob_q, disp_rob_d;
  logic [TAG_DEPTH-1:0]       tag_mem_q, tag_mem_d;
  logic [PW-1:0]              wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]              rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]              count_q, count_d;
  logic                       underflow_q, underflow_d;

  logic accept, ld_win, st_win, push, pop, fifo_empty, head_id;

  always_comb begin
    accept   = !reset && !flush && (count_q < DEPTH_C) && (!disp_valid_q || dispatch_ready);
    ld_win   = ld_valid && (!st_valid || rr_q == RR_LD);
    st_win   = st_valid && (!ld_valid || rr_q == RR_ST);
    ld_ready = accept && ld_win;
    st_ready = accept && st_win;
    push     = ld_ready || st_ready;
  end

  // Results with no recorded owner (empty FIFO or flush cycle) are accepted and dropped.
  always_comb begin
    fifo_empty   = (count_q == '0);
    head_id      = tag_mem_q[rd_ptr_q];
    ld_res_valid = 1'b0;
    st_res_valid = 1'b0;
    calc_ready   = 1'b1;
    if (!flush && !fifo_empty) begin
      if (head_id == RR_ST) begin
        st_res_valid = calc_valid;
        calc_ready   = st_res_ready;
      end else begin
        ld_res_valid = calc_valid;
        calc_ready   = ld_res_ready;
      end
    end
    pop = calc_valid && calc_ready && !fifo_empty && !flush;
  end

  always_comb begin
    rr_d         = rr_q;
    disp_valid_d = disp_valid_q;
    disp_1st_d   = disp_1st_q;
    disp_2nd_d   = disp_2nd_q;
    disp_addr_d  = disp_addr_q;
    disp_rob_d   = disp_rob_q;
    tag_mem_d    = tag_mem_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    count_d      = count_q;
    underflow_d  = underflow_q || (calc_valid && fifo_empty);
    if (flush) begin
      rr_d         = RR_LD;
      disp_valid_d = 1'b0;
      wr_ptr_d     = '0;
      rd_ptr_d     = '0;
      count_d      = '0;
    end else begin
      if (push) begin
        tag_mem_d[wr_ptr_q] = st_win;
        wr_ptr_d            = wr_ptr_q + PW'(1);
        rr_d                = st_win ? RR_LD : RR_ST;
        disp_valid_d        = 1'b1;
        disp_1st_d          = st_win ? st_1st_reg   : ld_1st_reg;
        disp_2nd_d          = st_win ? st_2nd_reg   : ld_2nd_reg;
        disp_addr_d         = st_win ? st_address   : ld_address;
        disp_rob_d          = st_win ? st_ROB_index : ld_ROB_index;
      end else if (dispatch_ready) begin
        disp_valid_d = 1'b0;
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
      end
      count_d = count_q + CW'(push) - CW'(pop);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rr_q         <= RR_LD;
      disp_valid_q <= 1'b0;
      disp_1st_q   <= '0;
      disp_2nd_q   <= '0;
      disp_addr_q  <= '0;
      disp_rob_q   <= '0;
      tag_mem_q    <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      underflow_q  <= 1'b0;
    end else begin
      rr_q         <= rr_d;
      disp_valid_q <= disp_valid_d;
      disp_1st_q   <= disp_1st_d;
      disp_2nd_q   <= disp_2nd_d;
      disp_addr_q  <= disp_addr_d;
      disp_rob_q   <= disp_rob_d;
      tag_mem_q    <= tag_mem_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      underflow_q  <= underflow_d;
    end
  end

  assign dispatch_valid     = disp_valid_q;
  assign dispatch_1st_reg   = disp_1st_q;
  assign dispatch_2nd_reg   = disp_2nd_q;
  assign dispatch_address   = disp_addr_q;
  assign dispatch_ROB_index = disp_rob_q;
  assign res_ROB_index      = calc_ROB_index;
  assign res_value          = calc_value;
  assign res_address        = calc_address;
  assign tag_underflow      = underflow_q;

endmodule

// File: tb/tb_addr_calc_arbiter.sv
// Bench for addr_calc_arbiter: directed scenarios plus a randomized run against a
// queue-based reference model of grant order, dispatch buffer and result ownership.
module tb_addr_calc_arbiter;

  localparam int XLEN = 64;
  localparam int RW   = 8;
  localparam int TAG_DEPTH = 4;

  logic            clock, reset, flush;
  logic            ld_valid, ld_ready, st_valid, st_ready;
  logic [XLEN-1:0] ld_1st_reg, ld_2nd_reg, ld_address;
  logic [XLEN-1:0] st_1st_reg, st_2nd_reg, st_address;
  logic [RW-1:0]   ld_ROB_index, st_ROB_index;
  logic            dispatch_valid, dispatch_ready;
  logic [XLEN-1:0] dispatch_1st_reg, dispatch_2nd_reg, dispatch_address;
  logic [RW-1:0]   dispatch_ROB_index;
  logic            calc_valid, calc_ready;
  logic [RW-1:0]   calc_ROB_index;
  logic [XLEN-1:0] calc_value, calc_address;
  logic            ld_res_valid, ld_res_ready, st_res_valid, st_res_ready;
  logic [RW-1:0]   res_ROB_index;
  logic [XLEN-1:0] res_value, res_address;
  logic            tag_underflow;

  int vectors = 0;
  int miscompares = 0;

  addr_calc_arbiter #(.XLEN(XLEN), .ROB_INDEX_WIDTH(RW), .TAG_DEPTH(TAG_DEPTH)) dut (
    .clock(clock), .reset(reset), .flush(flush),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_1st_reg(ld_1st_reg), .ld_2nd_reg(ld_2nd_reg),
    .ld_address(ld_address), .ld_ROB_index(ld_ROB_index),
    .st_valid(st_valid), .st_ready(st_ready), .st_1st_reg(st_1st_reg), .st_2nd_reg(st_2nd_reg),
    .st_address(st_address), .st_ROB_index(st_ROB_index),
    .dispatch_valid(dispatch_valid), .dispatch_ready(dispatch_ready),
    .dispatch_1st_reg(dispatch_1st_reg), .dispatch_2nd_reg(dispatch_2nd_reg),
    .dispatch_address(dispatch_address), .dispatch_ROB_index(dispatch_ROB_index),
    .calc_valid(calc_valid), .calc_ready(calc_ready), .calc_ROB_index(calc_ROB_index),
    .calc_value(calc_value), .calc_address(calc_address),
    .ld_res_valid(ld_res_valid), .ld_res_ready(ld_res_ready),
    .st_res_valid(st_res_valid), .st_res_ready(st_res_ready),
    .res_ROB_index(res_ROB_index), .res_value(res_value), .res_address(res_address),
    .tag_underflow(tag_underflow)
  );

  // clock / reset
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Inputs change 1 time unit after the rising edge; checks happen 1 unit later.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic drive_idle();
    flush = 0; ld_valid = 0; st_valid = 0; dispatch_ready = 0;
    calc_valid = 0; ld_res_ready = 1; st_res_ready = 1;
    ld_1st_reg = 0; ld_2nd_reg = 0; ld_address = 0; ld_ROB_index = 0;
    st_1st_reg = 0; st_2nd_reg = 0; st_address = 0; st_ROB_index = 0;
    calc_ROB_index = 0; calc_value = 0; calc_address = 0;
  endtask

  task automatic do_flush();
    drive_idle();
    flush = 1;
    tick();
    flush = 0;
  endtask

  task automatic test_reset();
    drive_idle();
    reset = 1; ld_valid = 1; st_valid = 1; dispatch_ready = 1;
    for (int i = 0; i < 3; i++) begin
      #1;
      vectors++; if (ld_ready !== 1'b0) begin miscompares++; $display("FAIL reset_ld_ready got %b exp 0", ld_ready); end
      vectors++; if (st_ready !== 1'b0) begin miscompares++; $display("FAIL reset_st_ready got %b exp 0", st_ready); end
      vectors++; if (dispatch_valid !== 1'b0) begin miscompares++; $display("FAIL reset_dispatch_valid got %b exp 0", dispatch_valid); end
      tick();
    end
    drive_idle();
    reset = 0;
    #1;
    vectors++; if (tag_underflow !== 1'b0) begin miscompares++; $display("FAIL reset_underflow got %b exp 0", tag_underflow); end
    vectors++; if (dispatch_address !== '0) begin miscompares++; $display("FAIL reset_payload got %h exp 0", dispatch_address); end
    tick();
  endtask

  task automatic test_single_load();
    drive_idle();
    ld_valid = 1; ld_ROB_index = 5; ld_address = 64'h100; dispatch_ready = 1;
    #1;
    vectors++; if (ld_ready !== 1'b1) begin miscompares++; $display("FAIL single_ld_ready got %b exp 1", ld_ready); end
    vectors++; if (st_ready !== 1'b0) begin miscompares++; $display("FAIL single_st_ready got %b exp 0", st_ready); end
    tick();
    ld_valid = 0;
    #1;
    vectors++; if (dispatch_valid !== 1'b1) begin miscompares++; $display("FAIL single_dvalid got %b exp 1", dispatch_valid); end
    vectors++; if (dispatch_ROB_index !== 8'd5) begin miscompares++; $display("FAIL single_drob got %0d exp 5", dispatch_ROB_index); end
    vectors++; if (dispatch_address !== 64'h100) begin miscompares++; $display("FAIL single_daddr got %h exp 100", dispatch_address); end
    tick();
    do_flush();
  endtask

  task automatic test_round_robin();
    logic [RW-1:0] exp_rob;
    drive_idle();
    ld_valid = 1; st_valid = 1; dispatch_ready = 1;
    for (int i = 0; i < 5; i++) begin
      ld_ROB_index = RW'(10 + i); st_ROB_index = RW'(20 + i);
      #1;
      vectors++; if (ld_ready !== (i < 4 && i % 2 == 0)) begin miscompares++; $display("FAIL rr_ld_ready cyc %0d got %b", i, ld_ready); end
      vectors++; if (st_ready !== (i < 4 && i % 2 == 1)) begin miscompares++; $display("FAIL rr_st_ready cyc %0d got %b", i, st_ready); end
      if (i > 0) begin
        exp_rob = (i % 2 == 1) ? RW'(10 + i - 1) : RW'(20 + i - 1);
        vectors++; if (dispatch_ROB_index !== exp_rob) begin miscompares++; $display("FAIL rr_drob cyc %0d got %0d exp %0d", i, dispatch_ROB_index, exp_rob); end
      end
      tick();
    end
    do_flush();
  endtask

  task automatic test_stall();
    drive_idle();
    st_valid = 1; st_ROB_index = 9; st_address = 64'h900;
    #1;
    vectors++; if (st_ready !== 1'b1) begin miscompares++; $display("FAIL stall_first_grant got %b exp 1", st_ready); end
    tick();
    ld_valid = 1; ld_ROB_index = 4; ld_address = 64'h400;
    st_ROB_index = 10; st_address = 64'hA00;
    for (int i = 0; i < 3; i++) begin
      #1;
      vectors++; if (dispatch_valid !== 1'b1) begin miscompares++; $display("FAIL stall_dvalid got %b exp 1", dispatch_valid); end
      vectors++; if (dispatch_ROB_index !== 8'd9) begin miscompares++; $display("FAIL stall_drob got %0d exp 9", dispatch_ROB_index); end
      vectors++; if (dispatch_address !== 64'h900) begin miscompares++; $display("FAIL stall_daddr got %h exp 900", dispatch_address); end
      vectors++; if ({ld_ready, st_ready} !== 2'b00) begin miscompares++; $display("FAIL stall_ready got %b exp 00", {ld_ready, st_ready}); end
      tick();
    end
    dispatch_ready = 1;
    #1;
    vectors++; if ({ld_ready, st_ready} !== 2'b10) begin miscompares++; $display("FAIL stall_release got %b exp 10", {ld_ready, st_ready}); end
    tick();
    ld_valid = 0; st_valid = 0;
    #1;
    vectors++; if (dispatch_ROB_index !== 8'd4) begin miscompares++; $display("FAIL stall_next_drob got %0d exp 4", dispatch_ROB_index); end
    tick();
    do_flush();
  endtask

  task automatic test_routing();
    drive_idle();
    dispatch_ready = 1;
    ld_valid = 1; ld_ROB_index = 3; tick();
    ld_valid = 0; st_valid = 1; st_ROB_index = 7; tick();
    st_valid = 0; tick();
    calc_valid = 1; calc_ROB_index = 3; calc_value = 64'hDEAD_0003; calc_address = 64'h3000;
    #1;
    vectors++; if ({ld_res_valid, st_res_valid} !== 2'b10) begin miscompares++; $display("FAIL route_ld got %b exp 10", {ld_res_valid, st_res_valid}); end
    vectors++; if (res_ROB_index !== 8'd3) begin miscompares++; $display("FAIL route_rob got %0d exp 3", res_ROB_index); end
    vectors++; if (res_value !== 64'hDEAD_0003) begin miscompares++; $display("FAIL route_value got %h", res_value); end
    vectors++; if (calc_ready !== 1'b1) begin miscompares++; $display("FAIL route_ld_cready got %b exp 1", calc_ready); end
    tick();
    calc_ROB_index = 7; calc_address = 64'h7000; st_res_ready = 0;
    for (int i = 0; i < 2; i++) begin
      #1;
      vectors++; if ({ld_res_valid, st_res_valid} !== 2'b01) begin miscompares++; $display("FAIL route_st cyc %0d got %b exp 01", i, {ld_res_valid, st_res_valid}); end
      vectors++; if (calc_ready !== 1'b0) begin miscompares++; $display("FAIL route_st_stall got %b exp 0", calc_ready); end
      tick();
    end
    st_res_ready = 1;
    #1;
    vectors++; if (calc_ready !== 1'b1 || res_address !== 64'h7000) begin miscompares++; $display("FAIL route_st_release got %b/%h exp 1/7000", calc_ready, res_address); end
    tick();
    calc_valid = 0;
    #1;
    vectors++; if (tag_underflow !== 1'b0) begin miscompares++; $display("FAIL route_no_underflow got %b exp 0", tag_underflow); end
    tick();
  endtask

  task automatic test_flush();
    drive_idle();
    dispatch_ready = 1;
    ld_valid = 1; ld_ROB_index = 1; tick();
    ld_valid = 0; st_valid = 1; st_ROB_index = 2; tick();
    st_valid = 0; dispatch_ready = 0;
    flush = 1; ld_valid = 1; calc_valid = 1; ld_res_ready = 0; st_res_ready = 0;
    #1;
    vectors++; if ({ld_ready, st_ready} !== 2'b00) begin miscompares++; $display("FAIL flush_ready got %b exp 00", {ld_ready, st_ready}); end
    vectors++; if ({ld_res_valid, st_res_valid} !== 2'b00) begin miscompares++; $display("FAIL flush_res_valid got %b exp 00", {ld_res_valid, st_res_valid}); end
    vectors++; if (calc_ready !== 1'b1) begin miscompares++; $display("FAIL flush_cready got %b exp 1", calc_ready); end
    tick();
    drive_idle();
    #1;
    vectors++; if (dispatch_valid !== 1'b0) begin miscompares++; $display("FAIL flush_dvalid got %b exp 0", dispatch_valid); end
    vectors++; if (tag_underflow !== 1'b0) begin miscompares++; $display("FAIL flush_uf_early got %b exp 0", tag_underflow); end
    tick();
    calc_valid = 1; calc_ROB_index = 8'h33; ld_res_ready = 0; st_res_ready = 0;
    #1;
    vectors++; if ({ld_res_valid, st_res_valid, calc_ready} !== 3'b001) begin miscompares++; $display("FAIL underflow_route got %b exp 001", {ld_res_valid, st_res_valid, calc_ready}); end
    tick();
    drive_idle();
    #1;
    vectors++; if (tag_underflow !== 1'b1) begin miscompares++; $display("FAIL underflow_set got %b exp 1", tag_underflow); end
    // an emptied FIFO must accept exactly TAG_DEPTH new requests
    ld_valid = 1; st_valid = 1; dispatch_ready = 1;
    for (int i = 0; i < TAG_DEPTH + 1; i++) begin
      #1;
      vectors++; if ((ld_ready || st_ready) !== (i < TAG_DEPTH)) begin miscompares++; $display("FAIL post_flush_depth cyc %0d got %b", i, ld_ready || st_ready); end
      tick();
    end
    do_flush();
    #1;
    vectors++; if (tag_underflow !== 1'b1) begin miscompares++; $display("FAIL underflow_sticky got %b exp 1", tag_underflow); end
    reset = 1;
    #1;
    vectors++; if ({tag_underflow, dispatch_valid} !== 2'b00) begin miscompares++; $display("FAIL async_reset got %b exp 00", {tag_underflow, dispatch_valid}); end
    tick();
    reset = 0;
    tick();
  endtask

  task automatic test_random();
    bit              pend[$];
    bit              rr;
    bit              m_dv, m_uf, e_ldr, e_str, e_ldv, e_stv, e_cr, can;
    int              win;
    logic [RW-1:0]   m_rob;
    logic [XLEN-1:0] m_1st, m_2nd, m_addr;
    rr = 0; m_dv = 0; m_uf = 0; m_rob = 0; m_1st = 0; m_2nd = 0; m_addr = 0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      flush          = ($urandom_range(0, 40) == 0);
      ld_valid       = $urandom_range(0, 1);
      st_valid       = $urandom_range(0, 1);
      dispatch_ready = ($urandom_range(0, 3) != 0);
      calc_valid     = ($urandom_range(0, 2) == 0);
      ld_res_ready   = ($urandom_range(0, 3) != 0);
      st_res_ready   = ($urandom_range(0, 3) != 0);
      ld_1st_reg = {$urandom, $urandom}; ld_2nd_reg = {$urandom, $urandom};
      ld_address = {$urandom, $urandom}; ld_ROB_index = RW'($urandom);
      st_1st_reg = {$urandom, $urandom}; st_2nd_reg = {$urandom, $urandom};
      st_address = {$urandom, $urandom}; st_ROB_index = RW'($urandom);
      calc_value = {$urandom, $urandom}; calc_address = {$urandom, $urandom};
      calc_ROB_index = RW'($urandom);
      // reference: who gets the slot, and who owns the oldest outstanding result
      can = !flush && (pend.size() < TAG_DEPTH) && (!m_dv || dispatch_ready);
      if (ld_valid && st_valid) win = rr;
      else if (ld_valid)        win = 0;
      else if (st_valid)        win = 1;
      else                      win = -1;
      e_ldr = can && (win == 0);
      e_str = can && (win == 1);
      e_ldv = 0; e_stv = 0; e_cr = 1;
      if (!flush && pend.size() > 0) begin
        if (pend[0]) begin e_stv = calc_valid; e_cr = st_res_ready; end
        else         begin e_ldv = calc_valid; e_cr = ld_res_ready; end
      end
      #1;
      vectors++; if ({ld_ready, st_ready} !== {e_ldr, e_str}) begin miscompares++; $display("FAIL rnd_ready cyc %0d got %b exp %b", cyc, {ld_ready, st_ready}, {e_ldr, e_str}); end
      vectors++; if ({ld_res_valid, st_res_valid, calc_ready} !== {e_ldv, e_stv, e_cr}) begin miscompares++; $display("FAIL rnd_route cyc %0d got %b exp %b", cyc, {ld_res_valid, st_res_valid, calc_ready}, {e_ldv, e_stv, e_cr}); end
      vectors++; if (dispatch_valid !== m_dv) begin miscompares++; $display("FAIL rnd_dvalid cyc %0d got %b exp %b", cyc, dispatch_valid, m_dv); end
      if (m_dv) begin
        vectors++; if ({dispatch_ROB_index, dispatch_address, dispatch_1st_reg, dispatch_2nd_reg} !== {m_rob, m_addr, m_1st, m_2nd}) begin miscompares++; $display("FAIL rnd_payload cyc %0d rob got %0d exp %0d addr got %h exp %h", cyc, dispatch_ROB_index, m_rob, dispatch_address, m_addr); end
      end
      vectors++; if ({res_ROB_index, res_value, res_address} !== {calc_ROB_index, calc_value, calc_address}) begin miscompares++; $display("FAIL rnd_res_bus cyc %0d", cyc); end
      vectors++; if (tag_underflow !== m_uf) begin miscompares++; $display("FAIL rnd_underflow cyc %0d got %b exp %b", cyc, tag_underflow, m_uf); end
      if (calc_valid && pend.size() == 0) m_uf = 1;
      if (flush) begin
        pend.delete(); m_dv = 0; rr = 0;
      end else begin
        if (calc_valid && e_cr && pend.size() > 0) void'(pend.pop_front());
        if (e_ldr || e_str) begin
          pend.push_back(e_str);
          rr = !e_str;
          m_dv = 1;
          m_rob  = e_str ? st_ROB_index : ld_ROB_index;
          m_addr = e_str ? st_address   : ld_address;
          m_1st  = e_str ? st_1st_reg   : ld_1st_reg;
          m_2nd  = e_str ? st_2nd_reg   : ld_2nd_reg;
        end else if (dispatch_ready) begin
          m_dv = 0;
        end
      end
      @(posedge clock);
      #1;
    end
    drive_idle();
  endtask

  initial begin
    reset = 1;
    drive_idle();
    test_reset();
    test_single_load();
    test_round_robin();
    test_stall();
    test_routing();
    test_flush();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
